// File: rtl/uart_fifo_bridge_pkg.sv
// Shared types and defaults for the UART FIFO bridge.
package uart_fifo_bridge_pkg;

    localparam int unsigned DEPTH_LOG2_DEF = 4;
    localparam int unsigned BYTE_W         = 8;

    // TX sequencer state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_fifo_bridge_byte_fifo.sv
// First-word fall-through byte FIFO with registered head, flags and count.
import uart_fifo_bridge_pkg::*;

module byte_fifo #(
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [BYTE_W-1:0]     i_din,
    input  logic                  i_pop,
    output logic [BYTE_W-1:0]     o_dout,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [BYTE_W-1:0] r_head;
    logic              r_full;
    logic              r_empty;

    logic              w_pop_ok;
    logic              w_push_ok;
    logic [PW-1:0]     w_rd_ptr_nxt;
    logic [CW-1:0]     w_count_nxt;
    logic [CW-1:0]     w_count_after_pop;
    logic [BYTE_W-1:0] w_head_nxt;

    // A push into a full FIFO is accepted only when a pop frees the slot this cycle
    assign w_pop_ok          = i_pop && !r_empty;
    assign w_push_ok         = i_push && (!r_full || w_pop_ok);
    assign w_rd_ptr_nxt      = w_pop_ok ? r_rd_ptr + PW'(1) : r_rd_ptr;
    assign w_count_after_pop = r_count - CW'(w_pop_ok);

    // Next occupancy and next head; a push into an emptied FIFO bypasses memory
    always_comb begin
        w_count_nxt = r_count;
        w_head_nxt  = '0;
        if (w_push_ok && !w_pop_ok) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_nxt = r_count - CW'(1);
        end
        if (w_count_nxt == '0) begin
            w_head_nxt = '0;
        end else if (w_push_ok && (w_count_after_pop == '0)) begin
            w_head_nxt = i_din;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    // Storage array write
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers, count, head and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_head   <= w_head_nxt;
            r_full   <= (w_count_nxt == CW'(DEPTH));
            r_empty  <= (w_count_nxt == '0);
        end
    end

    assign o_dout  = r_head;
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/uart_fifo_bridge.sv
// CPU-side byte buffering for the UART: TX FIFO plus send sequencer, RX FIFO plus overflow flag.
import uart_fifo_bridge_pkg::*;

module uart_fifo_bridge #(
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr_en,
    input  logic [7:0]           i_wr_data,
    input  logic                 i_rd_en,
    output logic [7:0]           o_rd_data,
    output logic                 o_tx_full,
    output logic                 o_tx_empty,
    output logic [DEPTH_LOG2:0]  o_tx_count,
    output logic                 o_rx_empty,
    output logic                 o_rx_full,
    output logic [DEPTH_LOG2:0]  o_rx_count,
    output logic                 o_rx_overflow,
    input  logic                 i_ovf_clr,
    output logic [7:0]           o_u_in,
    output logic                 o_u_send,
    input  logic                 i_u_tx_done,
    input  logic [7:0]           i_u_rx_data,
    input  logic                 i_u_rx_valid
);

    tx_state_t  r_state;
    tx_state_t  w_state_nxt;
    logic       w_tx_pop;
    logic       w_tx_push;
    logic [7:0] w_tx_head;
    logic       w_tx_fifo_empty;
    logic       w_rx_drop;

    logic       r_u_send;
    logic [7:0] r_u_in;
    logic       r_tx_empty;
    logic       r_rx_overflow;

    // CPU writes into a full TX FIFO are dropped even if the sequencer pops this cycle
    assign w_tx_push = i_wr_en && !o_tx_full;

    byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_push),
        .i_din   (i_wr_data),
        .i_pop   (w_tx_pop),
        .o_dout  (w_tx_head),
        .o_full  (o_tx_full),
        .o_empty (w_tx_fifo_empty),
        .o_count (o_tx_count)
    );

    byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (i_u_rx_valid),
        .i_din   (i_u_rx_data),
        .i_pop   (i_rd_en),
        .o_dout  (o_rd_data),
        .o_full  (o_rx_full),
        .o_empty (o_rx_empty),
        .o_count (o_rx_count)
    );

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next state; the FIFO pops at the end of ISSUE
    always_comb begin
        w_state_nxt = r_state;
        w_tx_pop    = 1'b0;
        case (r_state)
            ST_IDLE:  if (!w_tx_fifo_empty) w_state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                w_tx_pop    = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT:  if (i_u_tx_done) w_state_nxt = ST_GAP;
            ST_GAP:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered UART strobe/data and TX idle status; no pop can occur when heading to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_u_send   <= 1'b0;
            r_u_in     <= '0;
            r_tx_empty <= 1'b1;
        end else begin
            r_u_send   <= (w_state_nxt == ST_ISSUE);
            if (w_state_nxt == ST_ISSUE) begin
                r_u_in <= w_tx_head;
            end
            r_tx_empty <= (w_state_nxt == ST_IDLE) && w_tx_fifo_empty && !w_tx_push;
        end
    end

    // A received byte is lost only when the RX FIFO is full and not being read
    assign w_rx_drop = i_u_rx_valid && o_rx_full && !i_rd_en;

    // Sticky overflow flag; a new drop wins over a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_overflow <= 1'b0;
        end else if (w_rx_drop) begin
            r_rx_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            r_rx_overflow <= 1'b0;
        end
    end

    assign o_u_send      = r_u_send;
    assign o_u_in        = r_u_in;
    assign o_tx_empty    = r_tx_empty;
    assign o_rx_overflow = r_rx_overflow;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge: vector table plus multi-cycle sequences.
module tb_uart_fifo_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_wr_en = 1'b0;
    logic [7:0] i_wr_data = '0;
    logic       i_rd_en = 1'b0;
    logic [7:0] o_rd_data;
    logic       o_tx_full;
    logic       o_tx_empty;
    logic [4:0] o_tx_count;
    logic       o_rx_empty;
    logic       o_rx_full;
    logic [4:0] o_rx_count;
    logic       o_rx_overflow;
    logic       i_ovf_clr = 1'b0;
    logic [7:0] o_u_in;
    logic       o_u_send;
    logic       i_u_tx_done = 1'b0;
    logic [7:0] i_u_rx_data = '0;
    logic       i_u_rx_valid = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_wr_en       (i_wr_en),
        .i_wr_data     (i_wr_data),
        .i_rd_en       (i_rd_en),
        .o_rd_data     (o_rd_data),
        .o_tx_full     (o_tx_full),
        .o_tx_empty    (o_tx_empty),
        .o_tx_count    (o_tx_count),
        .o_rx_empty    (o_rx_empty),
        .o_rx_full     (o_rx_full),
        .o_rx_count    (o_rx_count),
        .o_rx_overflow (o_rx_overflow),
        .i_ovf_clr     (i_ovf_clr),
        .o_u_in        (o_u_in),
        .o_u_send      (o_u_send),
        .i_u_tx_done   (i_u_tx_done),
        .i_u_rx_data   (i_u_rx_data),
        .i_u_rx_valid  (i_u_rx_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic       rv;
        logic [7:0] rdat;
        logic       clr;
        logic       done;
        int         tc;
        int         rc;
        int         rdd;
        int         snd;
        int         uin;
        int         ovf;
        int         txe;
    } vec_t;

    vec_t vt [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        i_wr_en = 1'b0; i_wr_data = '0; i_rd_en = 1'b0; i_ovf_clr = 1'b0;
        i_u_tx_done = 1'b0; i_u_rx_data = '0; i_u_rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int   nsent;
        int   since;
        int   unstable;
        int   back2back;
        logic prev_send;
        logic [7:0] held;
        logic [7:0] sent [3];
        int   late_sends;

        // Table: reset idle, one TX byte through the sequencer, RX FWFT corners
        vt[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 8'h00, 0, 8'h00, 0, 1};
        vt[1]  = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 0, 8'h00, 0, 8'h00, 0, 0};
        vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 0, 8'h00, 1, 8'h41, 0, 0};
        vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 8'h00, 0, 8'h41, 0, 0};
        vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 0, 1, 8'hA5, 0, 8'h41, 0, 0};
        vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1, 8'hA5, 0, 8'h41, 0, 0};
        vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1, 8'hA5, 0, 8'h41, 0, 1};
        vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 8'h00, 0, 8'h41, 0, 1};
        vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 0, 1, 8'h11, 0, 8'h41, 0, 1};
        vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 0, 2, 8'h11, 0, 8'h41, 0, 1};
        vt[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1, 8'h22, 0, 8'h41, 0, 1};
        vt[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 0, 1, 8'h33, 0, 8'h41, 0, 1};
        vt[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 8'h00, 0, 8'h41, 0, 1};
        vt[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 8'h00, 0, 8'h41, 0, 1};
        vt[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 0, 8'h00, 0, 8'h41, 0, 1};
        vt[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 8'h00, 0, 8'h41, 0, 1};

        // Reset values while reset is held
        clear_inputs();
        tick();
        chk("rst_u_send", int'(o_u_send), 0);
        chk("rst_u_in", int'(o_u_in), 0);
        chk("rst_rd_data", int'(o_rd_data), 0);
        chk("rst_tx_count", int'(o_tx_count), 0);
        chk("rst_rx_count", int'(o_rx_count), 0);
        chk("rst_rx_empty", int'(o_rx_empty), 1);
        chk("rst_overflow", int'(o_rx_overflow), 0);
        chk("rst_tx_empty", int'(o_tx_empty), 1);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            i_wr_en = vt[i].wr;   i_wr_data = vt[i].wd; i_rd_en = vt[i].rd;
            i_u_rx_valid = vt[i].rv; i_u_rx_data = vt[i].rdat;
            i_ovf_clr = vt[i].clr; i_u_tx_done = vt[i].done;
            tick();
            chk($sformatf("v%0d_tx_count", i), int'(o_tx_count), vt[i].tc);
            chk($sformatf("v%0d_rx_count", i), int'(o_rx_count), vt[i].rc);
            chk($sformatf("v%0d_rd_data", i), int'(o_rd_data), vt[i].rdd);
            chk($sformatf("v%0d_u_send", i), int'(o_u_send), vt[i].snd);
            chk($sformatf("v%0d_u_in", i), int'(o_u_in), vt[i].uin);
            chk($sformatf("v%0d_overflow", i), int'(o_rx_overflow), vt[i].ovf);
            chk($sformatf("v%0d_tx_empty", i), int'(o_tx_empty), vt[i].txe);
        end

        // Three back-to-back writes drained with tx_done 10 cycles after each strobe
        do_reset();
        nsent = 0; since = -1; unstable = 0; back2back = 0; prev_send = 1'b0; held = '0;
        for (int c = 0; c < 120; c++) begin
            i_wr_en = (c < 3);
            i_wr_data = 8'h41 + 8'(c);
            i_u_tx_done = (since == 10);
            tick();
            if (since >= 0) since++;
            if (o_u_send) begin
                if (prev_send) back2back++;
                if (nsent < 3) sent[nsent] = o_u_in;
                nsent++;
                since = 0;
                held = o_u_in;
            end else if (nsent > 0 && o_u_in != held) begin
                unstable++;
            end
            prev_send = o_u_send;
        end
        clear_inputs();
        chk("seq_send_count", nsent, 3);
        chk("seq_byte0", int'(sent[0]), 8'h41);
        chk("seq_byte1", int'(sent[1]), 8'h42);
        chk("seq_byte2", int'(sent[2]), 8'h43);
        chk("seq_u_in_unstable", unstable, 0);
        chk("seq_back_to_back", back2back, 0);
        chk("seq_tx_empty", int'(o_tx_empty), 1);
        chk("seq_tx_count", int'(o_tx_count), 0);

        // Fill TX with done withheld; 18th write dropped
        do_reset();
        for (int i = 0; i < 17; i++) begin
            i_wr_en = 1'b1; i_wr_data = 8'h60 + 8'(i);
            tick();
        end
        chk("fill_tx_count", int'(o_tx_count), 16);
        chk("fill_tx_full", int'(o_tx_full), 1);
        chk("fill_u_in", int'(o_u_in), 8'h60);
        i_wr_data = 8'hEE;
        tick();
        i_wr_en = 1'b0;
        chk("fill_18th_count", int'(o_tx_count), 16);
        chk("fill_18th_full", int'(o_tx_full), 1);
        chk("fill_tx_empty", int'(o_tx_empty), 0);

        // Asynchronous reset during WAIT, then a late tx_done
        rst = 1'b1;
        #2;
        chk("mid_rst_u_send", int'(o_u_send), 0);
        chk("mid_rst_tx_count", int'(o_tx_count), 0);
        chk("mid_rst_tx_full", int'(o_tx_full), 0);
        chk("mid_rst_tx_empty", int'(o_tx_empty), 1);
        chk("mid_rst_u_in", int'(o_u_in), 0);
        tick();
        rst = 1'b0;
        i_u_tx_done = 1'b1;
        tick();
        i_u_tx_done = 1'b0;
        late_sends = int'(o_u_send);
        for (int i = 0; i < 6; i++) begin
            tick();
            late_sends += int'(o_u_send);
        end
        chk("late_done_sends", late_sends, 0);
        chk("late_done_tx_empty", int'(o_tx_empty), 1);
        chk("late_done_rx_count", int'(o_rx_count), 0);

        // RX fill, simultaneous push/pop when full, overflow and clear
        do_reset();
        for (int i = 0; i < 16; i++) begin
            i_u_rx_valid = 1'b1; i_u_rx_data = 8'(i);
            tick();
        end
        i_u_rx_valid = 1'b0;
        chk("rx_fill_count", int'(o_rx_count), 16);
        chk("rx_fill_full", int'(o_rx_full), 1);
        chk("rx_fill_ovf", int'(o_rx_overflow), 0);
        chk("rx_fill_head", int'(o_rd_data), 8'h00);
        i_u_rx_valid = 1'b1; i_u_rx_data = 8'h55; i_rd_en = 1'b1;
        tick();
        i_u_rx_valid = 1'b0; i_rd_en = 1'b0;
        chk("rx_both_count", int'(o_rx_count), 16);
        chk("rx_both_ovf", int'(o_rx_overflow), 0);
        chk("rx_both_head", int'(o_rd_data), 8'h01);
        i_u_rx_valid = 1'b1; i_u_rx_data = 8'hFF;
        tick();
        i_u_rx_valid = 1'b0;
        chk("rx_drop_ovf", int'(o_rx_overflow), 1);
        chk("rx_drop_count", int'(o_rx_count), 16);
        i_u_rx_valid = 1'b1; i_u_rx_data = 8'hEE; i_ovf_clr = 1'b1;
        tick();
        i_u_rx_valid = 1'b0; i_ovf_clr = 1'b0;
        chk("rx_set_beats_clr", int'(o_rx_overflow), 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("rx_read%0d", i), int'(o_rd_data), (i < 15) ? i + 1 : 8'h55);
            i_rd_en = 1'b1;
            tick();
        end
        i_rd_en = 1'b0;
        chk("rx_drain_empty", int'(o_rx_empty), 1);
        chk("rx_drain_rd_data", int'(o_rd_data), 0);
        chk("rx_drain_ovf_held", int'(o_rx_overflow), 1);
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        chk("rx_ovf_cleared", int'(o_rx_overflow), 0);

        // Push and pop on an empty RX FIFO: push only
        i_u_rx_valid = 1'b1; i_u_rx_data = 8'hA5; i_rd_en = 1'b1;
        tick();
        clear_inputs();
        chk("rx_empty_both_data", int'(o_rd_data), 8'hA5);
        chk("rx_empty_both_count", int'(o_rx_count), 1);
        chk("rx_empty_both_empty", int'(o_rx_empty), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
Byte-buffering stage between the CPU/IO bus and the UART wrapper. Holds a TX FIFO that the CPU fills; a TX sequencer drains it one byte at a time into the UART's parallel send interface. Holds an RX FIFO that captures every received-byte strobe from the UART for the CPU to read at leisure. Gives the CPU full/empty/count status and a sticky RX overflow flag.

Parameters:
DEPTH_LOG2, 4, log2 of each FIFO's depth (16 entries each).

Ports:
clk  in  1  system clock
rst  in  1  reset
wr_en  in  1  CPU push of wr_data into TX FIFO
wr_data  in  8  TX byte
rd_en  in  1  CPU pop of RX FIFO head
rd_data  out  8  RX FIFO head (first-word fall-through)
tx_full  out  1  TX FIFO full
tx_empty  out  1  TX FIFO empty and sequencer idle
tx_count  out  DEPTH_LOG2+1  TX FIFO occupancy
rx_empty  out  1  RX FIFO empty
rx_full  out  1  RX FIFO full
rx_count  out  DEPTH_LOG2+1  RX FIFO occupancy
rx_overflow  out  1  sticky: received byte dropped because RX FIFO was full
ovf_clr  in  1  clears rx_overflow
u_in  out  8  byte to UART transmitter
u_send  out  1  one-cycle start strobe to UART transmitter
u_tx_done  in  1  one-cycle pulse: UART finished the current byte
u_rx_data  in  8  received byte from UART
u_rx_valid  in  1  one-cycle pulse: u_rx_data valid

Behaviour:
- Reset rst, asynchronous, active-high; clock clk. On reset: both FIFOs empty, pointers 0, counts 0, rx_overflow 0, u_send 0, u_in 0, rd_data 0, sequencer in IDLE. Reset mid-transmission abandons the in-flight byte; the sequencer does not wait for u_tx_done.
- FIFOs: circular buffers of 2^DEPTH_LOG2 entries; pointers are DEPTH_LOG2 bits and wrap modulo depth; count is DEPTH_LOG2+1 bits, range 0..2^DEPTH_LOG2.
- TX push: wr_en while tx_full=1 is ignored (byte lost, no flag). A push and a sequencer pop in the same cycle are both performed; count unchanged.
- TX sequencer states:
  - IDLE: if TX FIFO non-empty -> ISSUE.
  - ISSUE (1 cycle): u_in <= head byte; u_send=1; pop TX FIFO -> WAIT.
  - WAIT: u_send=0; u_in held stable; on u_tx_done -> GAP.
  - GAP (1 cycle): -> IDLE. Guarantees at least 1 idle cycle between strobes.
- u_send is registered and never asserted on two consecutive cycles. Latency from wr_en into an empty idle bridge to u_send: 2 cycles (push cycle, then IDLE->ISSUE; u_send asserts in ISSUE).
- u_tx_done outside WAIT is ignored.
- tx_empty=1 only when TX FIFO count=0 and the sequencer is in IDLE.
- RX push: on u_rx_valid, store u_rx_data. If rx_full=1 and rd_en=0, the byte is dropped and rx_overflow is set. If rx_full=1 and rd_en=1 in the same cycle, pop and push both occur; no overflow.
- RX pop: rd_en with rx_empty=1 is ignored. rd_data is the head entry, valid whenever rx_empty=0, and 0 when empty. The next head appears the cycle after a pop.
- Simultaneous u_rx_valid and rd_en on an empty RX FIFO: push only; rx_empty deasserts the next cycle.
- rx_overflow: set has priority over ovf_clr in the same cycle.
- All status outputs reflect registered state; they update 1 cycle after the causing event.

Decomposition:
- Shared package: TX sequencer state encoding (IDLE=0, ISSUE=1, WAIT=2, GAP=3) and default DEPTH_LOG2.
- One sub-module: byte_fifo (parameterised FWFT FIFO with push/pop/full/empty/count), instantiated twice for TX and RX. The sequencer and overflow logic live in the top.

Test Plan:
- Write 0x41, 0x42, 0x43 back-to-back; u_tx_done pulses 10 cycles after each u_send -> exactly 3 u_send strobes carrying 0x41, 0x42, 0x43 in order; u_in stable through each WAIT; tx_empty=1 after the final GAP.
- Write 17 bytes with u_tx_done withheld -> the first byte moves to the UART, 16 remain queued, tx_full=1, and the 18th write is ignored; tx_count=16.
- Pulse u_rx_valid 16 times with 0x00..0x0F, then once with 0xFF -> rx_full=1, rx_overflow=1; CPU reads 0x00..0x0F and 0xFF never appears; ovf_clr clears the flag.
- RX full and u_rx_valid(0x55) coincide with rd_en -> head popped, 0x55 stored, rx_count stays 16, rx_overflow stays 0.
- Assert rst during WAIT, then release -> u_send=0, all counts=0, sequencer IDLE; a late u_tx_done pulse causes no strobe.
- u_rx_valid(0xA5) and rd_en on an empty RX FIFO -> the cycle after, rd_data=0xA5, rx_count=1.
